// File: rtl/video_fetch_pkg.sv
// ---------------------------------------------------------------------------
// video_fetch_pkg
// Shared definitions for the video fetch responder:
//   - fetch_state_e : responder FSM states
//   - LINE_WORDS    : 16-bit words per 64-bit video line
//   - ADDR_W        : word address width
//   - word_slot_lsb : maps a word index to its bit position in the line
//                     (word 0, lowest address, lands in [63:48])
// ---------------------------------------------------------------------------
package video_fetch_pkg;

    localparam int LINE_WORDS = 4;
    localparam int ADDR_W     = 23;

    typedef enum logic [1:0] {
        IDLE     = 2'd0,
        FETCH    = 2'd1,
        DONE     = 2'd2,
        PF_FETCH = 2'd3
    } fetch_state_e;

    // Lowest bit of the 16-bit slot that word idx occupies in the line.
    function automatic logic [5:0] word_slot_lsb(input logic [1:0] idx);
        return 6'd48 - {idx, 4'b0000};
    endfunction

endpackage

// File: rtl/video_line_buffer.sv
// ---------------------------------------------------------------------------
// video_line_buffer
// 4x16 assembly register for one video line. Each write stores a word into
// the slot selected by wr_idx; the whole 64-bit line is presented at once.
// Ports:
//   clk_32   in   system clock
//   reset_n  in   asynchronous active-low reset (clears the line)
//   wr_en    in   store wr_data this cycle
//   wr_idx   in   word index 0..3 (0 -> [63:48], 3 -> [15:0])
//   wr_data  in   16-bit word
//   line     out  assembled 64-bit line
// ---------------------------------------------------------------------------
module video_line_buffer
    import video_fetch_pkg::*;
(
    input  logic        clk_32,
    input  logic        reset_n,
    input  logic        wr_en,
    input  logic [1:0]  wr_idx,
    input  logic [15:0] wr_data,
    output logic [63:0] line
);

    logic [63:0] line_r;

    // Word capture into the slot selected by the write index
    always_ff @(posedge clk_32 or negedge reset_n) begin
        if (!reset_n) begin
            line_r <= 64'h0;
        end else if (wr_en) begin
            line_r[word_slot_lsb(wr_idx) +: 16] <= wr_data;
        end
    end

    assign line = line_r;

endmodule

// File: rtl/video_fetch_responder.sv
// ---------------------------------------------------------------------------
// video_fetch_responder
// Memory-side responder for the video fetch interface. A request sampled in
// the video bus slot triggers four 16-bit reads from the arbiter port; the
// words are assembled into one 64-bit line and published with a one-cycle
// data_valid pulse. A per-word watchdog aborts a stalled fetch.
//
// Optional feature (macro VIDEO_FETCH_PREFETCH_EN): after each line, the next
// line (base+4) is fetched speculatively into a second buffer; a request for
// that line is served without memory traffic.
//
// Ports:
//   clk_32      in   system clock
//   reset_n     in   asynchronous active-low reset
//   bus_cycle   in   bus-cycle phase (request sampled when == VIDEO_SLOT)
//   vaddr       in   word address of the line (bits [1:0] ignored)
//   read        in   fetch request
//   data        out  last fetched line (word 0 in [63:48])
//   data_valid  out  one-cycle pulse when data updates
//   mem_req     out  word read request to the arbiter
//   mem_addr    out  word address, stable while mem_req is high
//   mem_ack     in   arbiter accept; mem_rdata valid in the same cycle
//   mem_rdata   in   read word
//   overrun     out  sticky: request arrived while busy
//   timeout     out  sticky: a word exceeded TIMEOUT cycles
// ---------------------------------------------------------------------------
module video_fetch_responder
    import video_fetch_pkg::*;
#(
    parameter logic [1:0] VIDEO_SLOT = 2'd0,
    parameter int         TIMEOUT    = 64
) (
    input  logic        clk_32,
    input  logic        reset_n,
    input  logic [1:0]  bus_cycle,
    input  logic [22:0] vaddr,
    input  logic        read,
    output logic [63:0] data,
    output logic        data_valid,
    output logic        mem_req,
    output logic [22:0] mem_addr,
    input  logic        mem_ack,
    input  logic [15:0] mem_rdata,
    output logic        overrun,
    output logic        timeout
);

    localparam int             WD_W    = $clog2(TIMEOUT);
    localparam logic [WD_W-1:0] WD_LAST = WD_W'(TIMEOUT - 1);
    localparam logic [WD_W-1:0] WD_ONE  = WD_W'(1);
    localparam logic [WD_W-1:0] WD_ZERO = WD_W'(0);

    fetch_state_e      state_r, state_nx;
    logic [1:0]        idx_r, idx_nx;
    logic [22:0]       base_r, base_nx;
    logic [WD_W-1:0]   wdog_r, wdog_nx;
    logic              mem_req_r, mem_req_nx;
    logic [22:0]       mem_addr_r, mem_addr_nx;
    logic [63:0]       data_r, data_nx;
    logic              data_valid_r, data_valid_nx;
    logic              overrun_r, overrun_nx;
    logic              timeout_r, timeout_nx;

    logic              req_s;
    logic [22:0]       req_base_s;
    logic              buf_wr_s;
    logic [63:0]       line_s;
    logic              start_s;
    logic [22:0]       start_base_s;
    logic [1:0]        unused_vaddr_s;

    assign req_s          = read && (bus_cycle == VIDEO_SLOT);
    assign req_base_s     = {vaddr[22:2], 2'b00};
    assign unused_vaddr_s = vaddr[1:0];

    video_line_buffer u_line_buf (
        .clk_32  (clk_32),
        .reset_n (reset_n),
        .wr_en   (buf_wr_s),
        .wr_idx  (idx_r),
        .wr_data (mem_rdata),
        .line    (line_s)
    );

`ifdef VIDEO_FETCH_PREFETCH_EN
    logic [22:0]       pf_base_r, pf_base_nx;
    logic              pf_valid_r, pf_valid_nx;
    logic              hold_r, hold_nx;   // same-base request waiting on prefetch
    logic              abort_r, abort_nx; // other-base request pending in base_r
    logic              pf_wr_s;
    logic [63:0]       pf_line_s;

    video_line_buffer u_pf_buf (
        .clk_32  (clk_32),
        .reset_n (reset_n),
        .wr_en   (pf_wr_s),
        .wr_idx  (idx_r),
        .wr_data (mem_rdata),
        .line    (pf_line_s)
    );
`endif

    // Next-state and next-output logic of the fetch FSM
    always_comb begin
        state_nx      = state_r;
        idx_nx        = idx_r;
        base_nx       = base_r;
        wdog_nx       = wdog_r;
        mem_req_nx    = mem_req_r;
        mem_addr_nx   = mem_addr_r;
        data_nx       = data_r;
        data_valid_nx = 1'b0;
        overrun_nx    = overrun_r;
        timeout_nx    = timeout_r;
        buf_wr_s      = 1'b0;
        start_s       = 1'b0;
        start_base_s  = req_base_s;
`ifdef VIDEO_FETCH_PREFETCH_EN
        pf_base_nx    = pf_base_r;
        pf_valid_nx   = pf_valid_r;
        hold_nx       = hold_r;
        abort_nx      = abort_r;
        pf_wr_s       = 1'b0;
`endif
        case (state_r)
            IDLE: begin
                if (req_s) begin
`ifdef VIDEO_FETCH_PREFETCH_EN
                    if (pf_valid_r && (req_base_s == pf_base_r)) begin
                        data_nx       = pf_line_s;
                        data_valid_nx = 1'b1;
                    end else begin
                        start_s = 1'b1;
                    end
                    pf_valid_nx = 1'b0;
`else
                    start_s = 1'b1;
`endif
                end else begin
                    state_nx = IDLE;
                end
            end
            FETCH: begin
                if (req_s) begin
                    overrun_nx = 1'b1;
                end else begin
                    overrun_nx = overrun_r;
                end
                if (mem_ack) begin
                    buf_wr_s = 1'b1;
                    wdog_nx  = WD_ZERO;
                    if (idx_r == 2'd3) begin
                        state_nx   = DONE;
                        mem_req_nx = 1'b0;
                    end else begin
                        // base is line aligned, so the word index is just the low bits
                        idx_nx      = idx_r + 2'd1;
                        mem_addr_nx = {base_r[22:2], idx_r + 2'd1};
                    end
                end else if (wdog_r == WD_LAST) begin
                    mem_req_nx    = 1'b0;
                    data_nx       = 64'h0;
                    data_valid_nx = 1'b1;
                    timeout_nx    = 1'b1;
                    state_nx      = IDLE;
                end else begin
                    wdog_nx = wdog_r + WD_ONE;
                end
            end
            DONE: begin
                if (req_s) begin
                    overrun_nx = 1'b1;
                end else begin
                    overrun_nx = overrun_r;
                end
                data_nx       = line_s;
                data_valid_nx = 1'b1;
`ifdef VIDEO_FETCH_PREFETCH_EN
                // speculative fetch of the following line (address wraps)
                pf_base_nx  = base_r + 23'd4;
                pf_valid_nx = 1'b0;
                hold_nx     = 1'b0;
                abort_nx    = 1'b0;
                idx_nx      = 2'd0;
                wdog_nx     = WD_ZERO;
                mem_req_nx  = 1'b1;
                mem_addr_nx = base_r + 23'd4;
                state_nx    = PF_FETCH;
`else
                state_nx = IDLE;
`endif
            end
`ifdef VIDEO_FETCH_PREFETCH_EN
            PF_FETCH: begin
                if (req_s && (req_base_s == pf_base_r)) begin
                    hold_nx = 1'b1;
                end else if (req_s) begin
                    abort_nx = 1'b1;
                    base_nx  = req_base_s;
                end else begin
                    hold_nx = hold_r;
                end
                if (mem_ack) begin
                    pf_wr_s = 1'b1;
                    wdog_nx = WD_ZERO;
                    if (abort_nx) begin
                        start_s      = 1'b1;
                        start_base_s = base_nx;
                        pf_valid_nx  = 1'b0;
                        abort_nx     = 1'b0;
                        hold_nx      = 1'b0;
                    end else if (idx_r == 2'd3) begin
                        mem_req_nx = 1'b0;
                        state_nx   = IDLE;
                        if (hold_nx) begin
                            // last word goes to [15:0]; merge it straight into the output
                            data_nx       = {pf_line_s[63:16], mem_rdata};
                            data_valid_nx = 1'b1;
                            pf_valid_nx   = 1'b0;
                            hold_nx       = 1'b0;
                        end else begin
                            pf_valid_nx = 1'b1;
                        end
                    end else begin
                        idx_nx      = idx_r + 2'd1;
                        mem_addr_nx = {pf_base_r[22:2], idx_r + 2'd1};
                    end
                end else if (wdog_r == WD_LAST) begin
                    // a stalled speculative fetch is dropped silently
                    mem_req_nx  = 1'b0;
                    state_nx    = IDLE;
                    pf_valid_nx = 1'b0;
                    if (abort_nx) begin
                        start_s      = 1'b1;
                        start_base_s = base_nx;
                    end else if (hold_nx) begin
                        start_s      = 1'b1;
                        start_base_s = pf_base_r;
                    end else begin
                        start_s = 1'b0;
                    end
                    abort_nx = 1'b0;
                    hold_nx  = 1'b0;
                end else begin
                    wdog_nx = wdog_r + WD_ONE;
                end
            end
`endif
            default: begin
                state_nx   = IDLE;
                mem_req_nx = 1'b0;
            end
        endcase

        if (start_s) begin
            state_nx    = FETCH;
            base_nx     = start_base_s;
            idx_nx      = 2'd0;
            wdog_nx     = WD_ZERO;
            mem_req_nx  = 1'b1;
            mem_addr_nx = start_base_s;
        end else begin
            state_nx = state_nx;
        end
    end

    // State and registered outputs
    always_ff @(posedge clk_32 or negedge reset_n) begin
        if (!reset_n) begin
            state_r      <= IDLE;
            idx_r        <= 2'd0;
            base_r       <= 23'd0;
            wdog_r       <= WD_ZERO;
            mem_req_r    <= 1'b0;
            mem_addr_r   <= 23'd0;
            data_r       <= 64'h0;
            data_valid_r <= 1'b0;
            overrun_r    <= 1'b0;
            timeout_r    <= 1'b0;
        end else begin
            state_r      <= state_nx;
            idx_r        <= idx_nx;
            base_r       <= base_nx;
            wdog_r       <= wdog_nx;
            mem_req_r    <= mem_req_nx;
            mem_addr_r   <= mem_addr_nx;
            data_r       <= data_nx;
            data_valid_r <= data_valid_nx;
            overrun_r    <= overrun_nx;
            timeout_r    <= timeout_nx;
        end
    end

`ifdef VIDEO_FETCH_PREFETCH_EN
    // Prefetch bookkeeping registers
    always_ff @(posedge clk_32 or negedge reset_n) begin
        if (!reset_n) begin
            pf_base_r  <= 23'd0;
            pf_valid_r <= 1'b0;
            hold_r     <= 1'b0;
            abort_r    <= 1'b0;
        end else begin
            pf_base_r  <= pf_base_nx;
            pf_valid_r <= pf_valid_nx;
            hold_r     <= hold_nx;
            abort_r    <= abort_nx;
        end
    end
`endif

    assign data       = data_r;
    assign data_valid = data_valid_r;
    assign mem_req    = mem_req_r;
    assign mem_addr   = mem_addr_r;
    assign overrun    = overrun_r;
    assign timeout    = timeout_r;

endmodule
